cf_gpio_in_filter: RTL and testbench

- Digital input conditioner placed directly downstream of the GPIO pad configuration wrapper. It consumes the raw `io_in` pad value that the wrapper passes through.
- Resynchronises the asynchronous pad level into the `clk` domain.
- Rejects glitches with a programmable debounce window.
- Produces one-cycle rise/fall pulses and a sticky, clearable interrupt flag for user logic.
- One instance per input-capable GPIO: MODE INPUT, INPUT_PD, INPUT_PU or BIDIR.

---
 rtl/cf_gpio_in_filter.sv | 149 ++++++++++++++
 tb/tb_cf_gpio_in_filter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cf_gpio_in_filter.sv
// GPIO input conditioner: pad synchroniser, debounce FSM, edge pulses and sticky irq flag.
// Define CF_GPIO_IN_FILTER_EVCNT_EN to add the saturating selected-edge event counter.
module cf_gpio_in_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int DBNC_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io_in,
  input  logic              en,
  input  logic [DBNC_W-1:0] dbnc_thresh,
  input  logic [1:0]        edge_sel,
  input  logic              irq_clr,
  output logic              pin_sync,
  output logic              pin_filt,
  output logic              rise_pulse,
  output logic              fall_pulse,
`ifdef CF_GPIO_IN_FILTER_EVCNT_EN
  output logic              irq_flag,
  input  logic              ev_cnt_clr,
  output logic [15:0]       ev_cnt
`else
  output logic              irq_flag
`endif
);

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
      $error("cf_gpio_in_filter: SYNC_STAGES must be in 2..4");
    end
  endgenerate

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_QUALIFY = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [DBNC_W-1:0]      cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   filt_prev_q, filt_prev_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   irq_q, irq_d;
  logic                   sync_bit;
  logic                   differs;
  logic                   sel_evt;

  assign sync_bit = sync_q[SYNC_STAGES-1];
  assign differs  = sync_bit != filt_q;
  // Events are taken from the registered pulses, so a clear in the pulse cycle loses to the set.
  assign sel_evt  = (edge_sel[0] & rise_q) | (edge_sel[1] & fall_q);

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], io_in};
    state_d     = state_q;
    cnt_d       = cnt_q;
    filt_d      = filt_q;
    filt_prev_d = filt_q;
    rise_d      = filt_q & ~filt_prev_q;
    fall_d      = ~filt_q & filt_prev_q;
    irq_d       = sel_evt | (irq_q & ~irq_clr);

    case (state_q)
      ST_STABLE: begin
        cnt_d = '0;
        if (en && differs) begin
          if (dbnc_thresh == '0) begin
            filt_d = sync_bit;
          end else begin
            cnt_d   = {{(DBNC_W-1){1'b0}}, 1'b1};
            state_d = ST_QUALIFY;
          end
        end
      end
      ST_QUALIFY: begin
        if (!en || !differs) begin
          cnt_d   = '0;
          state_d = ST_STABLE;
        end else if (cnt_q >= dbnc_thresh) begin
          // >= lets a threshold lowered mid-qualify commit on the next edge.
          filt_d  = sync_bit;
          cnt_d   = '0;
          state_d = ST_STABLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_STABLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      state_q     <= ST_STABLE;
      cnt_q       <= '0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      irq_q       <= irq_d;
    end
  end

  assign pin_sync   = sync_bit;
  assign pin_filt   = filt_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign irq_flag   = irq_q;

`ifdef CF_GPIO_IN_FILTER_EVCNT_EN
  logic [15:0] ev_cnt_q, ev_cnt_d;

  // Clear has priority over a coincident event; the count sticks at all-ones.
  always_comb begin
    ev_cnt_d = ev_cnt_q;
    if (ev_cnt_clr) begin
      ev_cnt_d = '0;
    end else if (sel_evt && ev_cnt_q != 16'hFFFF) begin
      ev_cnt_d = ev_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_cnt_q <= '0;
    end else begin
      ev_cnt_q <= ev_cnt_d;
    end
  end

  assign ev_cnt = ev_cnt_q;
`endif

endmodule

// File: tb/tb_cf_gpio_in_filter.sv
// Testbench for cf_gpio_in_filter: reference model feeds an expectation queue, a monitor pops and compares.
module tb_cf_gpio_in_filter;

  localparam int SYNC = 2;
  localparam int DW   = 8;

  logic          clk;
  logic          rst;
  logic          io_in;
  logic          en;
  logic [DW-1:0] dbnc_thresh;
  logic [1:0]    edge_sel;
  logic          irq_clr;
  logic          ev_cnt_clr;
  logic          pin_sync, pin_filt, rise_pulse, fall_pulse, irq_flag;
  logic [15:0]   ev_cnt;

  cf_gpio_in_filter #(.SYNC_STAGES(SYNC), .DBNC_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .io_in       (io_in),
    .en          (en),
    .dbnc_thresh (dbnc_thresh),
    .edge_sel    (edge_sel),
    .irq_clr     (irq_clr),
    .pin_sync    (pin_sync),
    .pin_filt    (pin_filt),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
`ifdef CF_GPIO_IN_FILTER_EVCNT_EN
    .irq_flag    (irq_flag),
    .ev_cnt_clr  (ev_cnt_clr),
    .ev_cnt      (ev_cnt)
`else
    .irq_flag    (irq_flag)
`endif
  );

`ifndef CF_GPIO_IN_FILTER_EVCNT_EN
  assign ev_cnt = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: pin_sync is io_in delayed by SYNC edges; pin_filt follows pin_sync
  // once it has disagreed for D+1 consecutive enabled edges; pulses mark filt changes.
  logic [20:0] exp_q[$];
  bit          m_hist[$];
  bit          m_filt, m_prev, m_rise, m_fall, m_irq, m_evt, m_sync_old;
  int          m_run;
  logic [15:0] m_ev;

  always @(posedge clk) begin
    if (rst) begin
      m_hist = {};
      for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
      m_filt = 0; m_prev = 0; m_rise = 0; m_fall = 0; m_irq = 0; m_run = 0; m_ev = '0;
    end else begin
      m_sync_old = m_hist[SYNC-1];
      m_evt = (edge_sel[0] && m_rise) || (edge_sel[1] && m_fall);
      m_irq = m_evt || (m_irq && !irq_clr);
`ifdef CF_GPIO_IN_FILTER_EVCNT_EN
      if (ev_cnt_clr) m_ev = '0;
      else if (m_evt && m_ev != 16'hFFFF) m_ev = m_ev + 16'd1;
`endif
      m_rise = m_filt && !m_prev;
      m_fall = !m_filt && m_prev;
      m_prev = m_filt;
      if (!en || m_sync_old == m_filt) m_run = 0;
      else if (m_run >= int'(dbnc_thresh)) begin
        m_filt = m_sync_old;
        m_run  = 0;
      end else m_run++;
      m_hist.push_front(io_in);
      void'(m_hist.pop_back());
    end
    exp_q.push_back({m_ev, m_hist[SYNC-1], m_filt, m_rise, m_fall, m_irq});
  end

  always @(negedge clk) begin
    logic [20:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rst) e = '0;
      check("outputs", {11'd0, ev_cnt, pin_sync, pin_filt, rise_pulse, fall_pulse, irq_flag},
            {11'd0, e});
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Call right after changing io_in on a negedge; reports the first edge index where each output matches.
  task automatic trace(input bit val, input int n, output int t_sync, output int t_filt,
                       output int t_pls, output int n_pls);
    t_sync = -1; t_filt = -1; t_pls = -1; n_pls = 0;
    for (int e = 1; e <= n; e++) begin
      @(negedge clk);
      if (t_sync < 0 && pin_sync == val) t_sync = e;
      if (t_filt < 0 && pin_filt == val) t_filt = e;
      if (val ? rise_pulse : fall_pulse) begin
        n_pls++;
        if (t_pls < 0) t_pls = e;
      end
    end
  endtask

  task automatic wait_pulse(input bit rise, input string nm);
    int k;
    k = 0;
    while (!(rise ? rise_pulse : fall_pulse) && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (k >= 60) check({nm, "_timeout"}, 32'd1, 32'd0);
  endtask

  int ts, tf, tp, np;

  initial begin
    rst = 1'b1; io_in = 1'b0; en = 1'b1; dbnc_thresh = '0; edge_sel = 2'b00;
    irq_clr = 1'b0; ev_cnt_clr = 1'b0;
    cycles(3);
    check("reset_outputs", {pin_sync, pin_filt, rise_pulse, fall_pulse, irq_flag}, 32'd0);
    #2 rst = 1'b0;
    cycles(3);

    // D=0: sync after 2 edges, filt after 3, rise pulse on edge 4 only
    io_in = 1'b1;
    trace(1'b1, 8, ts, tf, tp, np);
    check("d0_sync_edge", ts, 2);
    check("d0_filt_edge", tf, 3);
    check("d0_pulse_edge", tp, 4);
    check("d0_pulse_count", np, 1);
    check("d0_irq_none", irq_flag, 0);

    io_in = 1'b0;
    cycles(8);
    dbnc_thresh = 8'd4;
    cycles(2);

    // 4-cycle glitch with D=4 is rejected
    io_in = 1'b1;
    cycles(4);
    io_in = 1'b0;
    trace(1'b1, 14, ts, tf, tp, np);
    check("glitch_filt", tf, -1);
    check("glitch_pulse", np, 0);

    // held high with D=4: 2+4+1 edges
    io_in = 1'b1;
    trace(1'b1, 12, ts, tf, tp, np);
    check("accept_filt_edge", tf, 7);
    check("accept_pulse_count", np, 1);

    // edge_sel = fall only
    dbnc_thresh = 8'd2;
    io_in = 1'b0;
    cycles(12);
    edge_sel = 2'b10;
    irq_clr = 1'b1; @(negedge clk); irq_clr = 1'b0;
    io_in = 1'b1;
    cycles(12);
    check("irq_after_rise", irq_flag, 0);
    io_in = 1'b0;
    wait_pulse(1'b0, "fall1");
    @(negedge clk);
    check("irq_after_fall", irq_flag, 1);
    irq_clr = 1'b1; @(negedge clk); irq_clr = 1'b0;
    check("irq_clr_alone", irq_flag, 0);
    io_in = 1'b1;
    cycles(12);
    io_in = 1'b0;
    wait_pulse(1'b0, "fall2");
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    check("irq_set_wins", irq_flag, 1);
    irq_clr = 1'b1; @(negedge clk); irq_clr = 1'b0;
    check("irq_clr_second", irq_flag, 0);
    cycles(6);

    // D=10, disable at counter 5, re-enable needs 11 edges
    dbnc_thresh = 8'd10;
    edge_sel = 2'b11;
    io_in = 1'b1;
    cycles(7);
    en = 1'b0;
    cycles(20);
    check("disabled_hold", pin_filt, 0);
    en = 1'b1;
    trace(1'b1, 16, ts, tf, tp, np);
    check("reenable_filt_edge", tf, 11);

    // async reset at counter 7 while pin_filt is 1
    io_in = 1'b0;
    cycles(9);
    #2 rst = 1'b1;
    #1 check("async_rst_filt", pin_filt, 0);
    check("async_rst_sync", pin_sync, 0);
    cycles(2);
    #2 rst = 1'b0;
    cycles(2);
    io_in = 1'b1;
    trace(1'b1, 18, ts, tf, tp, np);
    check("post_rst_latency", tf, SYNC + 10 + 1);

    // randomized phase
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) dbnc_thresh = DW'($urandom_range(0, 6));
      if (c % 60 == 0) edge_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) io_in = ~io_in;
      en = ($urandom_range(0, 24) != 0);
      irq_clr = ($urandom_range(0, 7) == 0);
`ifdef CF_GPIO_IN_FILTER_EVCNT_EN
      ev_cnt_clr = ($urandom_range(0, 40) == 0);
`endif
      @(negedge clk);
    end
    en = 1'b1; irq_clr = 1'b0; ev_cnt_clr = 1'b0; io_in = 1'b0;
    dbnc_thresh = '0;
    cycles(20);

`ifdef CF_GPIO_IN_FILTER_EVCNT_EN
    edge_sel = 2'b11;
    ev_cnt_clr = 1'b1; @(negedge clk); ev_cnt_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      io_in = 1'b1; cycles(8);
      io_in = 1'b0; cycles(8);
    end
    check("ev_cnt_six", ev_cnt, 6);
    io_in = 1'b1;
    wait_pulse(1'b1, "ev_clr_rise");
    ev_cnt_clr = 1'b1;
    @(negedge clk);
    ev_cnt_clr = 1'b0;
    check("ev_cnt_clr_wins", ev_cnt, 0);
    cycles(4);
    edge_sel = 2'b00;
    cycles(4);
    @(posedge clk);
    #1 force dut.ev_cnt_q = 16'hFFFE;
    m_ev = 16'hFFFE;
    exp_q[exp_q.size()-1][20:5] = 16'hFFFE;
    @(posedge clk);
    #1 release dut.ev_cnt_q;
    edge_sel = 2'b11;
    io_in = 1'b0; cycles(8);
    io_in = 1'b1; cycles(8);
    io_in = 1'b0; cycles(8);
    check("ev_cnt_saturate", ev_cnt, 16'hFFFF);
`endif

    cycles(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
